// File: rtl/usb_pkt_tx.sv
// usb_pkt_tx -- USB full-speed packet transmitter.
//
// Serialises SYNC, PID, an optional payload and CRC16 onto the D+/D- pads,
// with bit stuffing and NRZI encoding, and closes every packet with an EOP
// (two bit times of SE0 followed by one bit time of J).
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset (aborts a packet, no EOP)
//   tx_start_i  one-cycle start request, honoured only while idle
//   tx_pid_i    4-bit PID, captured with tx_start_i
//   tx_data_i   payload byte, valid while tx_valid_i=1
//   tx_valid_i  another payload byte is available
//   tx_ready_o  one-cycle pulse: tx_data_i is consumed in this cycle
//   tx_busy_o   packet in progress
//   tx_en_o     pad output enable
//   dp_tx_o     D+ drive value
//   dn_tx_o     D- drive value
module usb_pkt_tx #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_start_i,
  input  logic [3:0] tx_pid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_en_o,
  output logic       dp_tx_o,
  output logic       dn_tx_o
);

  localparam int PW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
  } state_t;

  // The registers describe the bit currently on the line: which field it
  // belongs to, its index in the byte, and whether it is an inserted stuff bit.
  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;     // shreg[0] is the bit on the line
  logic [7:0]    hold, hold_n;       // next payload byte, captured on tx_ready_o
  logic          have, have_n;       // hold contains a byte still to be sent
  logic [15:0]   crc, crc_n;
  logic [2:0]    ones, ones_n;
  logic          stuff, stuff_n;
  logic          data_pkt, data_pkt_n;
  logic          line, line_n;       // NRZI level: 1 = J, 0 = K
  logic          se0, se0_n;
  logic          en, en_n;

  logic tick, stuffable;
  logic emit, emit_bit, emit_crc;

  // Reflected CRC16 (x^16+x^15+x^2+1), one bit, LSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction

  assign tick      = (presc == PW'(CLK_PER_BIT - 1));
  assign stuffable = state inside {PID, DATA, CRC_LO, CRC_HI};

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    presc_n    = presc;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    hold_n     = hold;
    have_n     = have;
    crc_n      = crc;
    ones_n     = ones;
    stuff_n    = stuff;
    data_pkt_n = data_pkt;
    line_n     = line;
    se0_n      = se0;
    en_n       = en;
    tx_ready_o = 1'b0;
    emit       = 1'b0;
    emit_bit   = 1'b1;
    emit_crc   = 1'b0;

    // Fetch the next payload byte while the last bit of PID or of the
    // current byte is on the line, leaving the rest of that bit time to
    // decide between another DATA byte and the CRC.
    if ((state == DATA || (state == PID && data_pkt)) &&
        bit_cnt == 3'd7 && !stuff && presc == '0) begin
      tx_ready_o = tx_valid_i;
      have_n     = tx_valid_i;
      if (tx_valid_i) hold_n = tx_data_i;
    end

    if (state == IDLE) begin
      presc_n = '0;
      if (tx_start_i) begin
        state_n    = SYNC;
        bit_cnt_n  = 3'd0;
        shreg_n    = {~tx_pid_i, tx_pid_i};
        data_pkt_n = (tx_pid_i[1:0] == 2'b11);
        crc_n      = 16'hFFFF;
        ones_n     = 3'd0;
        stuff_n    = 1'b0;
        have_n     = 1'b0;
        en_n       = 1'b1;
        se0_n      = 1'b0;
        line_n     = 1'b0;   // first SYNC bit is 0: J -> K
      end
    end else begin
      presc_n = tick ? '0 : presc + PW'(1);
      if (tick) begin
        stuff_n = 1'b0;
        if (stuffable && ones == 3'd6 && !stuff) begin
          // Insert a 0 and hold the shifter and CRC where they are.
          emit     = 1'b1;
          emit_bit = 1'b0;
          stuff_n  = 1'b1;
        end else begin
          unique case (state)
            SYNC: begin
              emit = 1'b1;
              if (bit_cnt != 3'd7) begin
                bit_cnt_n = bit_cnt + 3'd1;
                emit_bit  = (bit_cnt == 3'd6);   // 0x80 LSB-first
              end else begin
                state_n   = PID;
                bit_cnt_n = 3'd0;
                emit_bit  = shreg[0];
              end
            end
            PID, DATA, CRC_LO, CRC_HI: begin
              if (bit_cnt != 3'd7) begin
                emit      = 1'b1;
                bit_cnt_n = bit_cnt + 3'd1;
                shreg_n   = {1'b0, shreg[7:1]};
                emit_bit  = shreg[1];
                emit_crc  = (state == DATA);
              end else if (state == CRC_LO) begin
                emit      = 1'b1;
                state_n   = CRC_HI;
                bit_cnt_n = 3'd0;
                shreg_n   = ~crc[15:8];
                emit_bit  = ~crc[8];
              end else if (state == CRC_HI || (state == PID && !data_pkt)) begin
                state_n   = EOP_SE0;
                bit_cnt_n = 3'd0;
                se0_n     = 1'b1;
              end else if (have) begin
                emit      = 1'b1;
                state_n   = DATA;
                bit_cnt_n = 3'd0;
                shreg_n   = hold;
                emit_bit  = hold[0];
                emit_crc  = 1'b1;
              end else begin
                // Payload ended; crc already covers every payload bit.
                emit      = 1'b1;
                state_n   = CRC_LO;
                bit_cnt_n = 3'd0;
                shreg_n   = ~crc[7:0];
                emit_bit  = ~crc[0];
              end
            end
            EOP_SE0: begin
              if (bit_cnt == 3'd0) begin
                bit_cnt_n = 3'd1;
              end else begin
                state_n = EOP_J;
                se0_n   = 1'b0;
                line_n  = 1'b1;
              end
            end
            EOP_J: begin
              state_n = IDLE;
              en_n    = 1'b0;
              line_n  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end
    end

    if (emit) begin
      se0_n  = 1'b0;
      line_n = emit_bit ? line : ~line;
      if (stuff_n || state_n == SYNC) ones_n = 3'd0;
      else                            ones_n = emit_bit ? ones + 3'd1 : 3'd0;
    end
    if (emit_crc) crc_n = crc_step(crc, emit_bit);
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      presc    <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      hold     <= 8'h00;
      have     <= 1'b0;
      crc      <= 16'h0000;
      ones     <= 3'd0;
      stuff    <= 1'b0;
      data_pkt <= 1'b0;
      line     <= 1'b1;
      se0      <= 1'b0;
      en       <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      hold     <= hold_n;
      have     <= have_n;
      crc      <= crc_n;
      ones     <= ones_n;
      stuff    <= stuff_n;
      data_pkt <= data_pkt_n;
      line     <= line_n;
      se0      <= se0_n;
      en       <= en_n;
    end
  end

  assign tx_busy_o = (state != IDLE);
  assign tx_en_o   = en;
  assign dp_tx_o   = line & ~se0;
  assign dn_tx_o   = ~line & ~se0;

endmodule

// File: tb/tb_usb_pkt_tx.sv
// tb_usb_pkt_tx -- self-checking bench for usb_pkt_tx.
//
// A reference model builds the expected line symbols of each packet from the
// packet rules (bytes -> bits -> stuffing -> NRZI -> EOP); an independent
// receiver decodes the captured trace back to bytes and checks the CRC residual.
module tb_usb_pkt_tx;

  localparam int CPB = 4;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [1:0] sym_q_t[$];
  typedef bit         bit_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_en, dp, dn;

  int n_checks = 0;
  int n_pass   = 0;
  byte_q_t pay;

  always #5 clk = ~clk;

  usb_pkt_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_start_i(tx_start),
    .tx_pid_i  (tx_pid),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .tx_busy_o (tx_busy),
    .tx_en_o   (tx_en),
    .dp_tx_o   (dp),
    .dn_tx_o   (dn)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Raw reflected CRC16 register (init 0xFFFF, no final complement).
  function automatic logic [15:0] crc_raw(input byte_q_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i])
      for (int j = 0; j < 8; j++)
        c = (c >> 1) ^ ((c[0] ^ d[i][j]) ? 16'hA001 : 16'h0000);
    return c;
  endfunction

  // Expected line symbols, one per bit time.
  function automatic sym_q_t model_line(input logic [3:0] pid, input byte_q_t data);
    byte_q_t     body;
    bit_q_t      bits;
    sym_q_t      syms;
    logic [15:0] c;
    logic [1:0]  lvl;
    int          ones;
    bit          b;
    body.push_back({~pid, pid});
    if (pid[1:0] == 2'b11) begin
      foreach (data[i]) body.push_back(data[i]);
      c = ~crc_raw(data);
      body.push_back(c[7:0]);
      body.push_back(c[15:8]);
    end
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    ones = 0;
    foreach (body[i])
      for (int j = 0; j < 8; j++) begin
        b = body[i][j];
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    lvl = SYM_J;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
      syms.push_back(lvl);
    end
    syms.push_back(SYM_SE0);
    syms.push_back(SYM_SE0);
    syms.push_back(SYM_J);
    return syms;
  endfunction

  // Receiver: per-clock trace -> bytes after SYNC (PID first).
  function automatic byte_q_t decode(input sym_q_t trace);
    bit_q_t     raw, clean;
    byte_q_t    out;
    logic [1:0] prev, s;
    logic [7:0] acc;
    int         ones;
    prev = SYM_J;
    for (int k = 0; k * CPB + CPB / 2 < trace.size(); k++) begin
      s = trace[k * CPB + CPB / 2];
      if (s == SYM_SE0) break;
      raw.push_back(s == prev);
      prev = s;
    end
    ones = 0;
    for (int i = 8; i < raw.size(); i++) begin
      if (ones == 6) begin
        ones = 0;
        continue;
      end
      clean.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
    end
    for (int i = 0; i + 8 <= clean.size(); i += 8) begin
      for (int j = 0; j < 8; j++) acc[j] = clean[i + j];
      out.push_back(acc);
    end
    return out;
  endfunction

  task automatic drive_byte(input int idx);
    tx_valid = (idx < pay.size());
    tx_data  = (idx < pay.size()) ? pay[idx] : 8'($urandom);
  endtask

  task automatic run_packet(input logic [3:0] pid, input int second_at);
    sym_q_t  exp_sym, got;
    byte_q_t dec, tail;
    int cyc, idx, ready_cnt, first_ready, last_ready, min_gap, mism, eops, budget, exp_rdy;
    bit pend, done, is_data;
    is_data = (pid[1:0] == 2'b11);
    exp_sym = model_line(pid, pay);
    budget  = exp_sym.size() * CPB + 40;
    idx = 0; ready_cnt = 0; first_ready = -1; last_ready = -1; min_gap = 1 << 30;
    pend = 1'b0; done = 1'b0; cyc = 0;

    @(negedge clk);
    tx_pid   = pid;
    tx_start = 1'b1;
    drive_byte(0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("busy_start", 32'(tx_busy), 32'd1);

    while (!done && cyc < budget) begin
      @(negedge clk);
      if (tx_en) got.push_back({dp, dn});
      else       done = 1'b1;
      if (tx_ready) begin
        if (last_ready >= 0 && cyc - last_ready < min_gap) min_gap = cyc - last_ready;
        if (first_ready < 0) first_ready = cyc;
        last_ready = cyc;
        ready_cnt++;
        pend = 1'b1;
      end
      @(posedge clk); #1;
      if (pend) begin
        idx++;
        drive_byte(idx);
        pend = 1'b0;
      end
      tx_start = (second_at > 0 && cyc == second_at);
      cyc++;
    end
    tx_start = 1'b0;
    tx_valid = 1'b0;

    check("timeout", 32'(done), 32'd1);
    check("en_cycles", 32'(got.size()), 32'(exp_sym.size() * CPB));
    mism = 0;
    for (int i = 0; i < got.size() && i / CPB < exp_sym.size(); i++)
      if (got[i] !== exp_sym[i / CPB]) mism++;
    check("line", 32'(mism), 32'd0);

    exp_rdy = is_data ? pay.size() : 0;
    check("ready_cnt", 32'(ready_cnt), 32'(exp_rdy));
    if (exp_rdy > 0) check("first_ready", 32'(first_ready), 32'(15 * CPB));
    if (ready_cnt >= 2) check("ready_gap", 32'(min_gap >= 8 * CPB), 32'd1);

    eops = 0;
    foreach (got[i])
      if (got[i] == SYM_SE0 && (i == 0 || got[i - 1] != SYM_SE0)) eops++;
    check("eop_cnt", 32'(eops), 32'd1);

    dec = decode(got);
    check("pid_byte", (dec.size() > 0) ? 32'(dec[0]) : 32'hDEAD_BEEF, 32'({~pid, pid}));
    if (is_data) begin
      check("pay_len", 32'(dec.size()), 32'(pay.size() + 3));
      if (dec.size() >= 3) begin
        tail = dec[1:$];
        mism = 0;
        foreach (pay[i]) if (i + 1 < dec.size() && dec[i + 1] !== pay[i]) mism++;
        check("pay_data", 32'(mism), 32'd0);
        check("crc_resid", 32'(crc_raw(tail)), 32'h0000_B001);
      end
    end else begin
      check("byte_cnt", 32'(dec.size()), 32'd1);
    end

    repeat (3 * CPB) @(negedge clk);
    check("idle_after", 32'({tx_en, tx_busy}), 32'd0);
  endtask

  task automatic reset_mid_data();
    int idx;
    bit pend;
    pay = {};
    repeat (12) pay.push_back(8'($urandom));
    idx = 0;
    pend = 1'b0;
    @(negedge clk);
    tx_pid   = 4'h3;
    tx_start = 1'b1;
    drive_byte(0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (40 * CPB) begin
      @(negedge clk);
      if (tx_ready) pend = 1'b1;
      @(posedge clk); #1;
      if (pend) begin
        idx++;
        drive_byte(idx);
        pend = 1'b0;
      end
    end
    check("mid_pkt_en", 32'({tx_en, tx_busy}), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 32'({tx_en, dp, dn, tx_busy, tx_ready}), 32'b01000);
    @(negedge clk);
    tx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_idle", 32'({tx_en, dp, dn, tx_busy}), 32'b0100);
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_pid   = 4'h0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'({tx_en, dp, dn, tx_busy, tx_ready}), 32'b01000);
    rst = 1'b0;

    // ACK, nothing to consume.
    pay = {};
    run_packet(4'h2, 0);
    // DATA0 with empty payload: CRC bytes are 0x00 0x00.
    pay = {};
    run_packet(4'h3, 0);
    // DATA1 with all-ones payload forces stuffing.
    pay = {8'hFF, 8'hFF};
    run_packet(4'hB, 0);
    // Long random DATA0 payload.
    pay = {};
    repeat (64) pay.push_back(8'($urandom));
    run_packet(4'h3, 0);
    // A second start during the payload must be ignored.
    pay = {};
    repeat (10) pay.push_back(8'($urandom));
    run_packet(4'h3, 30 * CPB);
    // Random PIDs; PID-only packets see valid=1 but must not consume.
    repeat (6) begin
      pay = {};
      repeat ($urandom_range(0, 6)) pay.push_back(8'($urandom));
      run_packet(4'($urandom), 0);
    end
    // Abort mid-DATA, then a clean ACK.
    reset_mid_data();
    pay = {};
    run_packet(4'h2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
